tdoa_capture_arbiter: RTL and testbench

- Collects timestamp events from N_CH per-microphone Timer channels. Each channel raises a detect-valid with its captured time and holds it until acked.
- Arbitrates round-robin onto one output stream with a valid/ready handshake, and returns a one-cycle ack to the winning channel.
- Groups events into frames (at most one event per channel per frame) for downstream TDOA processing.
- Sits between the Timer bank and the result/UART formatter.

---
 rtl/tdoa_pkg.sv | 26 ++
 rtl/tdoa_capture_arbiter_rr_arbiter.sv | 33 +++
 rtl/tdoa_capture_arbiter.sv | 137 +++++++++++++
 tb/tb_tdoa_capture_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tdoa_pkg.sv
// Shared types and defaults for the TDOA capture arbiter.
// Holds the FSM encoding, default sizes and a constant clog2 helper.
package tdoa_pkg;

  localparam int DEF_N_CH     = 4;
  localparam int DEF_TS_W     = 32;
  localparam int DEF_FRAME_TO = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPEN,
    ST_PRESENT,
    ST_CLOSE
  } state_t;

  // Never returns less than 1 so single-entry fields stay legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tdoa_capture_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just above ptr.
// Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter
  import tdoa_pkg::*;
#(
  parameter  int N  = DEF_N_CH,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int i = 1; i <= N; i++) begin
      c = IW'((int'(ptr) + i) % N);
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/tdoa_capture_arbiter.sv
// Round-robin capture of timer events into frames for TDOA processing.
// Define TDOA_ARB_REL_TIME_EN to emit times relative to frame start.
module tdoa_capture_arbiter
  import tdoa_pkg::*;
#(
  parameter  int N_CH     = DEF_N_CH,
  parameter  int TS_W     = DEF_TS_W,
  parameter  int FRAME_TO = DEF_FRAME_TO,
  localparam int CH_W     = clog2(N_CH),
  localparam int CNT_W    = clog2(FRAME_TO + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_valid,
  input  logic [N_CH*TS_W-1:0]   ch_time,
  output logic [N_CH-1:0]        ch_ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH_W-1:0]        out_ch,
  output logic [TS_W-1:0]        out_time,
  output logic                   frame_done,
  output logic [N_CH-1:0]        frame_mask
);

  localparam logic [CNT_W-1:0] TO      = CNT_W'(FRAME_TO);
  localparam logic [CH_W-1:0]  PTR_RST = CH_W'(N_CH - 1);

  state_t            state;
  logic [N_CH-1:0]   seen;
  logic [N_CH-1:0]   elig;
  logic [N_CH-1:0]   gnt;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   gidx;
  logic              gany;
  logic [CNT_W-1:0]  cnt;
  logic              timeout;
  logic              hs;
  logic              can_grant;
  logic              opening;
  logic [TS_W-1:0]   gtime;
  logic [TS_W-1:0]   word_time;

  assign elig      = ch_valid & ~seen;
  assign timeout   = (cnt >= TO);
  assign hs        = out_valid && out_ready;
  assign gtime     = ch_time[int'(gidx)*TS_W +: TS_W];
  assign opening   = (state == ST_IDLE);
  assign can_grant = gany &&
                     (opening || (state == ST_OPEN && !timeout));

  rr_arbiter #(
    .N (N_CH)
  ) u_arb (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

`ifdef TDOA_ARB_REL_TIME_EN
  // Base is the first timestamp of the frame; subtraction wraps mod 2^TS_W.
  logic [TS_W-1:0] base;

  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
    end else if (can_grant && opening) begin
      base <= gtime;
    end
  end

  assign word_time = opening ? '0 : (gtime - base);
`else
  assign word_time = gtime;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      seen       <= '0;
      cnt        <= '0;
      ptr        <= PTR_RST;
      ch_ack     <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_time   <= '0;
      frame_done <= 1'b0;
      frame_mask <= '0;
    end else begin
      ch_ack     <= '0;
      frame_done <= 1'b0;
      frame_mask <= '0;
      if ((state == ST_OPEN || state == ST_PRESENT) && !timeout) begin
        cnt <= cnt + 1'b1;
      end
      unique case (state)
        ST_IDLE, ST_OPEN: begin
          if (can_grant) begin
            out_valid <= 1'b1;
            out_ch    <= gidx;
            out_time  <= word_time;
            ch_ack    <= gnt;
            seen      <= seen | gnt;
            ptr       <= gidx;
            state     <= ST_PRESENT;
            if (opening) cnt <= CNT_W'(1);
          end else if (state == ST_OPEN && timeout) begin
            frame_done <= 1'b1;
            frame_mask <= seen;
            state      <= ST_CLOSE;
          end
        end
        ST_PRESENT: begin
          // The held word always completes before the frame may close.
          if (hs) begin
            out_valid <= 1'b0;
            if ((&seen) || timeout) begin
              frame_done <= 1'b1;
              frame_mask <= seen;
              state      <= ST_CLOSE;
            end else begin
              state <= ST_OPEN;
            end
          end
        end
        ST_CLOSE: begin
          seen  <= '0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdoa_capture_arbiter.sv
// Directed vector bench for tdoa_capture_arbiter (N_CH=4, FRAME_TO=8).
// Expected times follow TDOA_ARB_REL_TIME_EN when it is defined.
module tb_tdoa_capture_arbiter;

  localparam int N   = 4;
  localparam int TW  = 32;
  localparam int FTO = 8;
`ifdef TDOA_ARB_REL_TIME_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_valid;
  logic [N*TW-1:0] ch_time;
  logic [N-1:0]    ch_ack;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_ch;
  logic [TW-1:0]   out_time;
  logic            frame_done;
  logic [N-1:0]    frame_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdoa_capture_arbiter #(
    .N_CH     (N),
    .TS_W     (TW),
    .FRAME_TO (FTO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_valid   (ch_valid),
    .ch_time    (ch_time),
    .ch_ack     (ch_ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_time   (out_time),
    .frame_done (frame_done),
    .frame_mask (frame_mask)
  );

  typedef struct {
    logic        r;
    logic [3:0]  valid;
    logic        ready;
    logic [3:0]  ack;
    logic        ov;
    logic [1:0]  och;
    logic [31:0] otime;
    logic        done;
    logic [3:0]  mask;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic [3:0] val,
                             input logic rdy, input logic [3:0] ack,
                             input logic ov, input logic [1:0] och,
                             input logic [31:0] ot, input logic d,
                             input logic [3:0] m);
    vec_t x;
    x.r = r; x.valid = val; x.ready = rdy;
    x.ack = ack; x.ov = ov; x.och = och;
    x.otime = ot; x.done = d; x.mask = m;
    return x;
  endfunction

  function automatic logic [31:0] t(input logic [31:0] raw,
                                    input logic [31:0] rel);
    return REL ? rel : raw;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] val,
                      input logic rdy);
    rst       = r;
    ch_valid  = val;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string nm, input logic [3:0] ack,
                          input logic [1:0] och, input logic [31:0] ot);
    chk({nm, ".ack"}, 32'(ch_ack), 32'(ack));
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".ch"}, 32'(out_ch), 32'(och));
    chk({nm, ".time"}, out_time, ot);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".ack"}, 32'(ch_ack), 32'd0);
    chk({nm, ".valid"}, 32'(out_valid), 32'd0);
    chk({nm, ".ch"}, 32'(out_ch), 32'd0);
    chk({nm, ".time"}, out_time, 32'd0);
    chk({nm, ".done"}, 32'(frame_done), 32'd0);
    chk({nm, ".mask"}, 32'(frame_mask), 32'd0);
  endtask

  task automatic set_times();
    ch_time = {32'h310, 32'h210, 32'h110, 32'h10};
  endtask

  initial begin
    string nm;
    rst = 1'b1; ch_valid = '0; out_ready = 1'b1;
    set_times();

    // single channel, closes on timeout at counter == 8
    tbl.push_back(v(1, 4'h0, 1, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'h1, 1, 4'h1, 1, 0, t(32'h10, 0), 0, 4'h0));
    tbl.push_back(v(0, 4'h1, 1, 4'h0, 0, 0, 0, 0, 4'h0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(v(0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'h0, 1, 4'h0, 0, 0, 0, 1, 4'h1));
    tbl.push_back(v(0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 4'h0));
    // all four at once: ch0..ch3, two cycles apart, full mask
    tbl.push_back(v(1, 4'h0, 1, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'hF, 1, 4'h1, 1, 0, t(32'h10, 0), 0, 4'h0));
    tbl.push_back(v(0, 4'hF, 1, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'hE, 1, 4'h2, 1, 1, t(32'h110, 32'h100), 0, 4'h0));
    tbl.push_back(v(0, 4'hE, 1, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'hC, 1, 4'h4, 1, 2, t(32'h210, 32'h200), 0, 4'h0));
    tbl.push_back(v(0, 4'hC, 1, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'h8, 1, 4'h8, 1, 3, t(32'h310, 32'h300), 0, 4'h0));
    tbl.push_back(v(0, 4'h8, 1, 4'h0, 0, 0, 0, 1, 4'hF));
    tbl.push_back(v(0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 4'h0));
    // ch0 re-requests in the same frame: held off until next frame
    tbl.push_back(v(0, 4'h1, 1, 4'h1, 1, 0, t(32'h10, 0), 0, 4'h0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(v(0, 4'h1, 1, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'h1, 1, 4'h0, 0, 0, 0, 1, 4'h1));
    tbl.push_back(v(0, 4'h1, 1, 4'h0, 0, 0, 0, 0, 4'h0));
    tbl.push_back(v(0, 4'h1, 1, 4'h1, 1, 0, t(32'h10, 0), 0, 4'h0));
    tbl.push_back(v(0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 4'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].valid, tbl[i].ready);
      nm = $sformatf("row%0d", i);
      chk({nm, ".ack"}, 32'(ch_ack), 32'(tbl[i].ack));
      chk({nm, ".valid"}, 32'(out_valid), 32'(tbl[i].ov));
      chk({nm, ".done"}, 32'(frame_done), 32'(tbl[i].done));
      if (tbl[i].ov) begin
        chk({nm, ".ch"}, 32'(out_ch), 32'(tbl[i].och));
        chk({nm, ".time"}, out_time, tbl[i].otime);
      end
      if (tbl[i].done || tbl[i].r)
        chk({nm, ".mask"}, 32'(frame_mask), 32'(tbl[i].mask));
    end

    // backpressure across the timeout: word held, then frame closes
    step(1, 4'h0, 0);
    chk_zero("bp_rst");
    step(0, 4'h4, 0);
    chk_word("bp_grant", 4'h4, 2'd2, t(32'h210, 0));
    for (int i = 0; i < 20; i++) begin
      step(0, 4'h2, 0);
      chk_word($sformatf("bp_hold%0d", i), 4'h0, 2'd2, t(32'h210, 0));
    end
    step(0, 4'h2, 1);
    chk("bp_close.done", 32'(frame_done), 32'd1);
    chk("bp_close.mask", 32'(frame_mask), 32'h4);
    chk("bp_close.valid", 32'(out_valid), 32'd0);
    chk("bp_close.ack", 32'(ch_ack), 32'd0);
    step(0, 4'h2, 1);
    chk("bp_idle.done", 32'(frame_done), 32'd0);
    chk("bp_idle.ack", 32'(ch_ack), 32'd0);
    step(0, 4'h2, 0);
    chk_word("bp_next", 4'h2, 2'd1, t(32'h110, 0));

    // reset mid-frame with a held word: everything cleared, no frame_done
    step(1, 4'h8, 0);
    chk_zero("mid_rst");
    step(0, 4'h8, 0);
    chk_word("post_rst", 4'h8, 2'd3, t(32'h310, 0));
    step(0, 4'h0, 1);
    chk("post_rst_hs.done", 32'(frame_done), 32'd0);
    chk("post_rst_hs.valid", 32'(out_valid), 32'd0);

    // timestamps across timer rollover
    step(1, 4'h0, 1);
    ch_time[1*TW +: TW] = 32'hFFFF_FFF0;
    ch_time[2*TW +: TW] = 32'h0000_0010;
    step(0, 4'h6, 1);
    chk_word("wrap_a", 4'h2, 2'd1, t(32'hFFFF_FFF0, 0));
    step(0, 4'h6, 1);
    chk("wrap_hs.valid", 32'(out_valid), 32'd0);
    step(0, 4'h4, 1);
    chk_word("wrap_b", 4'h4, 2'd2, t(32'h10, 32'h20));
    step(0, 4'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
